// File: rtl/pic_pkg.sv
// Shared constants, FSM state type and find-first-set helper for the PIC
// INTA/ISR controller.
package pic_pkg;
  localparam int NUM_IRQ = 8;
  localparam int LVL_W   = 3;

  localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ACK1,
    GAP,
    ACK2
  } state_t;

  typedef struct packed {
    logic             found;
    logic [LVL_W-1:0] idx;
  } lowest_t;

  // Index 0 is the highest priority, so the lowest set bit wins.
  function automatic lowest_t lowest_set(input logic [NUM_IRQ-1:0] vec);
    lowest_t res;
    res = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = LVL_W'(i);
      end
    end
    return res;
  endfunction
endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index find-first-set encoder; reports whether any bit is set and
// the index of the highest-priority (lowest) set bit.
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] vec_i,
  output logic               found_o,
  output logic [LVL_W-1:0]   idx_o
);
  lowest_t res;

  assign res     = lowest_set(vec_i);
  assign found_o = res.found;
  assign idx_o   = res.idx;
endmodule

// File: rtl/pic_inta_isr_ctrl.sv
// In-Service Register, INT request and two-pulse INTA vector sequencing for
// an 8259-style PIC. Optional auto-EOI is enabled with PIC_AUTO_EOI_EN.
//
//  state | meaning
//  IDLE  | no request outstanding, evaluating qualify
//  REQ   | int_o high, waiting for first INTA fall
//  ACK1  | first INTA pulse low, bus floated, waiting for rise
//  GAP   | between pulses, waiting for second INTA fall
//  ACK2  | second INTA pulse low, vector driven until rise
module pic_inta_isr_ctrl
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irr_req,
  output logic [NUM_IRQ-1:0] irr_clr,
  input  logic [4:0]         icw2_base,
  input  logic               inta_n,
  output logic               int_o,
  output logic [7:0]         data_o,
  output logic               data_oe,
  input  logic               eoi_valid,
  input  logic               eoi_specific,
  input  logic [LVL_W-1:0]   eoi_level,
  output logic [NUM_IRQ-1:0] isr
`ifdef PIC_AUTO_EOI_EN
  ,
  input  logic               aeoi_mode
`endif
);
  state_t             state_q;
  logic [LVL_W-1:0]   lvl_q;
  logic               spur_q;
  logic               inta_q;
  logic               int_q;
  logic [7:0]         data_q;
  logic               oe_q;
  logic [NUM_IRQ-1:0] irr_clr_q;
  logic [NUM_IRQ-1:0] isr_q;
  logic [NUM_IRQ-1:0] isr_d;

  logic               win_found;
  logic [LVL_W-1:0]   win_idx;
  logic               isr_found;
  logic [LVL_W-1:0]   isr_idx;
  logic               qualify;
  logic               fall;
  logic               rise;
  logic [NUM_IRQ-1:0] set_mask;
  logic [NUM_IRQ-1:0] clr_mask;

  pic_prio_enc u_req_enc (
    .vec_i   (irr_req),
    .found_o (win_found),
    .idx_o   (win_idx)
  );

  pic_prio_enc u_isr_enc (
    .vec_i   (isr_q),
    .found_o (isr_found),
    .idx_o   (isr_idx)
  );

  assign qualify = win_found && (!isr_found || (win_idx < isr_idx));
  assign fall    = inta_q && !inta_n;
  assign rise    = !inta_q && inta_n;

  // Set and clear are independent; when both target one bit the set wins.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if ((state_q == REQ) && fall && win_found) begin
      set_mask[win_idx] = 1'b1;
    end
    if (eoi_valid) begin
      if (eoi_specific) begin
        clr_mask[eoi_level] = 1'b1;
      end else if (isr_found) begin
        clr_mask[isr_idx] = 1'b1;
      end
    end
`ifdef PIC_AUTO_EOI_EN
    if (aeoi_mode && (state_q == ACK2) && rise && !spur_q) begin
      clr_mask[lvl_q] = 1'b1;
    end
`endif
    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      spur_q    <= 1'b0;
      inta_q    <= 1'b1;
      int_q     <= 1'b0;
      data_q    <= '0;
      oe_q      <= 1'b0;
      irr_clr_q <= '0;
      isr_q     <= '0;
    end else begin
      inta_q    <= inta_n;
      isr_q     <= isr_d;
      irr_clr_q <= '0;
      case (state_q)
        IDLE: begin
          if (qualify) begin
            int_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          // A fall is honoured even if the request vanished in the same cycle.
          if (fall) begin
            int_q   <= 1'b0;
            state_q <= ACK1;
            if (win_found) begin
              lvl_q     <= win_idx;
              spur_q    <= 1'b0;
              irr_clr_q <= set_mask;
            end else begin
              lvl_q  <= SPURIOUS_LVL;
              spur_q <= 1'b1;
            end
          end else if (!qualify) begin
            int_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        ACK1: begin
          if (rise) begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (fall) begin
            data_q  <= {icw2_base, lvl_q};
            oe_q    <= 1'b1;
            state_q <= ACK2;
          end
        end
        ACK2: begin
          if (rise) begin
            data_q  <= '0;
            oe_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign int_o   = int_q;
  assign data_o  = data_q;
  assign data_oe = oe_q;
  assign irr_clr = irr_clr_q;
  assign isr     = isr_q;
endmodule

// File: tb/tb_pic_inta_isr_ctrl.sv
// Bench for pic_inta_isr_ctrl: directed and randomized INTA/EOI traffic with a
// transaction-level ISR model and a scoreboard for irr_clr pulses and vectors.
module tb_pic_inta_isr_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irr_req;
  logic [7:0] irr_clr;
  logic [4:0] icw2_base;
  logic       inta_n;
  logic       int_o;
  logic [7:0] data_o;
  logic       data_oe;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic [7:0] isr;
  logic       aeoi_mode;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] vec_q[$];
  logic [7:0] clr_q[$];
  bit   [7:0] isr_m;
  bit   [7:0] req_m;
  logic       oe_prev = 1'b0;

  pic_inta_isr_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr_req      (irr_req),
    .irr_clr      (irr_clr),
    .icw2_base    (icw2_base),
    .inta_n       (inta_n),
    .int_o        (int_o),
    .data_o       (data_o),
    .data_oe      (data_oe),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .isr          (isr)
`ifdef PIC_AUTO_EOI_EN
    ,
    .aeoi_mode    (aeoi_mode)
`endif
  );

  always #5 clk = ~clk;

  function automatic int lowest(bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  // A request is taken only if its best level beats every in-service level.
  function automatic bit qualifies(bit [7:0] r, bit [7:0] s);
    if (r == 8'h00) return 1'b0;
    return lowest(r) < lowest(s);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: every irr_clr pulse and every vector presentation
  // must match the next expected item.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (irr_clr !== 8'h00) begin
          if (clr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL irr_clr_unexpected: got %0h expected none", irr_clr);
          end else begin
            check("irr_clr", irr_clr, clr_q.pop_front());
          end
        end
        if (data_oe === 1'b1 && oe_prev !== 1'b1) begin
          if (vec_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL vector_unexpected: got %0h expected none", data_o);
          end else begin
            check("vector", data_o, vec_q.pop_front());
          end
        end
      end
      oe_prev = data_oe;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic set_req(bit [7:0] r);
    req_m   = r;
    irr_req = r;
    tick(2);
    check("int_o", int_o, qualifies(req_m, isr_m));
  endtask

  task automatic do_eoi(bit spec, bit [2:0] l);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = l;
    tick(1);
    eoi_valid = 1'b0;
    if (spec) isr_m[l] = 1'b0;
    else if (isr_m != 0) isr_m[lowest(isr_m)] = 1'b0;
    tick(1);
    check("isr_eoi", isr, isr_m);
  endtask

  // Full two-pulse acknowledge; caller guarantees int_o is asserted.
  task automatic do_inta(bit spurious, bit with_eoi, bit eoi_spec, bit [2:0] eoi_lvl);
    bit [2:0] lvl;
    bit [7:0] setm;
    bit [7:0] clrm;
    if (spurious) begin
      req_m   = 8'h00;
      irr_req = 8'h00;
    end
    setm = 8'h00;
    if (req_m == 8'h00) begin
      lvl = 3'd7;
    end else begin
      lvl  = 3'(lowest(req_m));
      setm = 8'h01 << lvl;
      clr_q.push_back(setm);
    end
    clrm = 8'h00;
    if (with_eoi) begin
      eoi_valid    = 1'b1;
      eoi_specific = eoi_spec;
      eoi_level    = eoi_lvl;
      if (eoi_spec) clrm = 8'h01 << eoi_lvl;
      else if (isr_m != 0) clrm = 8'h01 << lowest(isr_m);
    end
    isr_m = (isr_m & ~clrm) | setm;
    vec_q.push_back({icw2_base, lvl});
    inta_n = 1'b0;
    tick(1);
    eoi_valid = 1'b0;
    check("oe_ack1", data_oe, 1'b0);
    check("int_o_ack", int_o, 1'b0);
    check("isr_fall", isr, isr_m);
    tick(1);
    inta_n = 1'b1;
    tick(2);
    inta_n = 1'b0;
    tick(1);
    check("oe_ack2", data_oe, 1'b1);
    tick(1);
    inta_n = 1'b1;
    tick(1);
`ifdef PIC_AUTO_EOI_EN
    if (aeoi_mode && !spurious && setm != 0) isr_m = isr_m & ~setm;
`endif
    check("oe_end", data_oe, 1'b0);
    check("isr_end", isr, isr_m);
    req_m   = req_m & ~setm;
    irr_req = req_m;
  endtask

  task automatic drop_req();
    req_m   = 8'h00;
    irr_req = 8'h00;
    tick(1);
    check("int_drop_1clk", int_o, 1'b0);
  endtask

  // INTA pulses while nothing is requested must never drive the bus.
  task automatic stray_inta();
    for (int k = 0; k < 2; k++) begin
      inta_n = 1'b0;
      tick(2);
      check("oe_stray", data_oe, 1'b0);
      inta_n = 1'b1;
      tick(2);
    end
  endtask

  initial begin
    int act;
    rst_n        = 1'b0;
    irr_req      = 8'h00;
    icw2_base    = 5'h10;
    inta_n       = 1'b1;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
    aeoi_mode    = 1'b0;
    isr_m        = 8'h00;
    req_m        = 8'h00;
    tick(2);
    check("rst_isr", isr, 8'h00);
    check("rst_int", int_o, 1'b0);
    check("rst_data", data_o, 8'h00);
    check("rst_oe", data_oe, 1'b0);
    check("rst_clr", irr_clr, 8'h00);
    rst_n = 1'b1;
    tick(1);

    set_req(8'h08);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);

    set_req(8'h04);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_req(8'h10);
    set_req(8'h02);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);

    set_req(8'h01);
    drop_req();
    set_req(8'h01);
    do_inta(1'b1, 1'b0, 1'b0, 3'd0);

    set_req(8'h04);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    set_req(8'h01);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    do_eoi(1'b0, 3'd0);
    do_eoi(1'b1, 3'd2);
    do_eoi(1'b1, 3'd6);

    set_req(8'h00);
    stray_inta();

    set_req(8'h08);
    do_inta(1'b0, 1'b1, 1'b1, 3'd3);
    do_eoi(1'b1, 3'd3);

`ifdef PIC_AUTO_EOI_EN
    aeoi_mode = 1'b1;
    set_req(8'h20);
    do_inta(1'b0, 1'b0, 1'b0, 3'd0);
    aeoi_mode = 1'b0;
`endif

    for (int it = 0; it < 60; it++) begin
      icw2_base = 5'($urandom);
`ifdef PIC_AUTO_EOI_EN
      aeoi_mode = 1'($urandom);
`endif
      if ($urandom_range(0, 3) == 0) set_req(8'h00);
      else set_req(8'($urandom));
      if (qualifies(req_m, isr_m)) begin
        act = $urandom_range(0, 5);
        if (act == 0) do_inta(1'b1, 1'b0, 1'b0, 3'd0);
        else if (act == 1) drop_req();
        else do_inta(1'b0, 1'($urandom), 1'($urandom), 3'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        stray_inta();
      end
      if ($urandom_range(0, 1) == 0) do_eoi(1'($urandom), 3'($urandom));
    end

    // Reset while the vector is on the bus.
    set_req(8'h00);
    while (isr_m != 0) do_eoi(1'b0, 3'd0);
    set_req(8'h40);
    vec_q.push_back({icw2_base, 3'd6});
    clr_q.push_back(8'h40);
    inta_n = 1'b0;
    tick(2);
    inta_n = 1'b1;
    tick(2);
    inta_n = 1'b0;
    tick(1);
    check("oe_before_rst", data_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", data_oe, 1'b0);
    check("rst_mid_int", int_o, 1'b0);
    check("rst_mid_isr", isr, 8'h00);
    check("rst_mid_data", data_o, 8'h00);
    isr_m = 8'h00;
    tick(1);
    inta_n  = 1'b1;
    req_m   = 8'h00;
    irr_req = 8'h00;
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("oe_after_rst", data_oe, 1'b0);
    check("isr_after_rst", isr, 8'h00);
    check("vec_q_empty", vec_q.size(), 0);
    check("clr_q_empty", clr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
